ab_symbol_driver: RTL



---
 rtl/ab_driver_pkg.sv | 14 +
 rtl/sat_counter.sv | 34 +++
 rtl/ab_symbol_driver.sv | 117 +++++++++++
 3 files changed

// File: rtl/ab_driver_pkg.sv
// Shared types and constants for the (a, b) symbol driver.
package ab_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned SYM_W = 2;
    localparam int unsigned A_BIT = 1;
    localparam int unsigned B_BIT = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ab_symbol_driver.sv
// Shifts a packed word of two-bit symbols onto the FSM's a/b inputs, advancing only
// when the FSM's Moore output says the symbol was consumed; counts hits and stalls.
module ab_symbol_driver
    import ab_driver_pkg::*;
#(
    parameter int unsigned NSYM  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SYM_W*NSYM-1:0] in_data,
    input  logic                  clr_cnt,
    input  logic                  fsm_y0,
    input  logic                  fsm_y1,
    output logic                  a,
    output logic                  b,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int unsigned DW    = SYM_W * NSYM;
    localparam int unsigned IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    state_e            state_d;
    state_e            state_q;
    logic [DW-1:0]     shreg_d;
    logic [DW-1:0]     shreg_q;
    logic [IDX_W-1:0]  sym_idx_d;
    logic [IDX_W-1:0]  sym_idx_q;
    logic              send;
    logic              hit_inc;
    logic              stall_inc;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        sym_idx_d = sym_idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d   = in_data;
                    sym_idx_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // y1 low means the FSM did not take the symbol: hold it on a/b.
                if (fsm_y1) begin
                    shreg_d   = shreg_q >> SYM_W;
                    sym_idx_d = sym_idx_q + IDX_W'(1);
                    if (sym_idx_q == IDX_W'(NSYM - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            sym_idx_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            sym_idx_q <= sym_idx_d;
        end
    end

    assign send      = (state_q == SEND);
    assign in_ready  = (state_q == IDLE);
    assign busy      = send;
    assign done      = (state_q == DONE);
    assign a         = send & shreg_q[A_BIT];
    assign b         = send & shreg_q[B_BIT];

    assign hit_inc   = send & fsm_y1 & fsm_y0;
    assign stall_inc = send & ~fsm_y1;

    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (hit_inc),
        .q       (hit_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr_cnt),
        .inc     (stall_inc),
        .q       (stall_count)
    );

endmodule
